// File: rtl/sm_trigger_arbiter.sv
// Round-robin arbiter that grants a shared 4-state sequencer to one client at a time,
// fires its start pulse, follows it to DONE and aborts it through a watchdog if it stalls.
module sm_trigger_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         sm_state,
    output logic               trigger,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    grant_id,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic               timeout_err
);

    localparam int         CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [1:0] SM_IDLE = 2'd0;
    localparam logic [1:0] SM_DONE = 2'd3;

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_FIRE  = 2'd1,
        A_TRACK = 2'd2,
        A_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_last;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_trigger;
    logic [NUM_REQ-1:0] r_gnt;
    logic [ID_W-1:0]    r_grant_id;
    logic [NUM_REQ-1:0] r_done;
    logic               r_busy;
    logic               r_timeout_err;

    logic [ID_W-1:0]    w_sel_id;
    logic [NUM_REQ-1:0] w_sel_oh;
    logic               w_launch;

    // Client index reached by stepping 'off' places past 'base', modulo NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % NUM_REQ;
        return ID_W'(sum);
    endfunction

    // Pick the first requester after the last winner; scanning backwards lets the nearest one win.
    always_comb begin
        w_sel_id = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_sel_id = req[wrap_idx(r_last, i)] ? wrap_idx(r_last, i) : w_sel_id;
        end
        w_sel_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_id;
        w_launch = (|req) && (sm_state == SM_IDLE);
    end

    // Arbitration / sequencing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= A_IDLE;
            r_last        <= ID_W'(NUM_REQ - 1);
            r_cnt         <= '0;
            r_trigger     <= 1'b0;
            r_gnt         <= '0;
            r_grant_id    <= '0;
            r_done        <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                A_IDLE: begin
                    r_done        <= '0;
                    r_timeout_err <= 1'b0;
                    if (w_launch) begin
                        r_gnt      <= w_sel_oh;
                        r_grant_id <= w_sel_id;
                        r_last     <= w_sel_id;
                        r_trigger  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= A_FIRE;
                    end else begin
                        r_trigger <= 1'b0;
                    end
                end
                A_FIRE: begin
                    r_trigger <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= A_TRACK;
                end
                A_TRACK: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Completion wins over the watchdog when both land on the same cycle.
                    if (sm_state == SM_DONE) begin
                        r_done  <= r_gnt;
                        r_state <= A_DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_gnt         <= '0;
                        r_busy        <= 1'b0;
                        r_state       <= A_IDLE;
                    end else begin
                        r_state <= A_TRACK;
                    end
                end
                A_DONE: begin
                    r_done  <= '0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= A_IDLE;
                end
                default: begin
                    r_state   <= A_IDLE;
                    r_trigger <= 1'b0;
                    r_gnt     <= '0;
                    r_done    <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign trigger     = r_trigger;
    assign gnt         = r_gnt;
    assign grant_id    = r_grant_id;
    assign done        = r_done;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sm_trigger_arbiter.sv
// Scoreboard bench for sm_trigger_arbiter: a transaction-level model predicts time-stamped
// trigger/done/timeout events and grant windows; a monitor compares them on every falling edge.
module tb_sm_trigger_arbiter;

    localparam int N   = 4;
    localparam int TMO = 15;
    localparam int IDW = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [1:0]     sm_state;
    logic           trigger;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] grant_id;
    logic [N-1:0]   done;
    logic           busy;
    logic           timeout_err;

    logic [1:0]   seq_st = 2'd0;
    logic         seq_stuck = 1'b0;
    logic [N-1:0] stuck_mask;
    logic         force_busy;

    assign sm_state = force_busy ? 2'd2 : seq_st;

    sm_trigger_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO), .ID_W(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .sm_state    (sm_state),
        .trigger     (trigger),
        .gnt         (gnt),
        .grant_id    (grant_id),
        .done        (done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared sequencer: IDLE->RUN on trigger, then WAIT, DONE, IDLE; a stuck run waits for the abort.
    always @(posedge clk) begin
        if (!rst) begin
            seq_st    <= 2'd0;
            seq_stuck <= 1'b0;
        end else begin
            case (seq_st)
                2'd0: if (trigger) begin
                    seq_st    <= 2'd1;
                    seq_stuck <= |(gnt & stuck_mask);
                end
                2'd1: if (!seq_stuck) seq_st <= 2'd2;
                      else if (timeout_err) seq_st <= 2'd0;
                2'd2: seq_st <= 2'd3;
                default: seq_st <= 2'd0;
            endcase
        end
    end

    typedef struct {
        int           at;
        int           kind;   // 0 trigger, 1 done, 2 timeout
        logic [N-1:0] val;
    } ev_t;

    ev_t          sb[$];
    int           edge_n = 0;
    int           free_at = 0;
    int           last_w;
    logic [N-1:0] g_val;
    int           g_clear;
    int           e_id;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, edge_n, act, exp);
        end
    endtask

    // Reference model: decides each grant from the round-robin rule and schedules its events.
    initial begin
        logic [N-1:0] one;
        int           w;
        one     = 1;
        last_w  = N - 1;
        g_val   = '0;
        g_clear = 0;
        e_id    = 0;
        forever begin
            @(posedge clk);
            edge_n++;
            if (!rst) begin
                last_w  = N - 1;
                free_at = edge_n + 1;
                g_clear = edge_n;
                e_id    = 0;
                while (sb.size() > 0 && sb[$].at >= edge_n) void'(sb.pop_back());
            end else if (edge_n >= free_at && req != '0 && sm_state == 2'd0) begin
                w = 0;
                for (int i = 1; i <= N; i++) begin
                    if (req[(last_w + i) % N]) begin
                        w = (last_w + i) % N;
                        break;
                    end
                end
                last_w = w;
                e_id   = w;
                g_val  = one << w;
                sb.push_back('{edge_n, 0, g_val});
                if (stuck_mask[w]) begin
                    sb.push_back('{edge_n + TMO + 1, 2, '0});
                    g_clear = edge_n + TMO + 1;
                    free_at = edge_n + TMO + 2;
                end else begin
                    sb.push_back('{edge_n + 4, 1, g_val});
                    g_clear = edge_n + 5;
                    free_at = edge_n + 6;
                end
            end
        end
    end

    // Monitor: pops the events due now and compares every output on the falling edge.
    initial begin
        logic         et;
        logic         eto;
        logic [N-1:0] ed;
        logic [N-1:0] etv;
        logic [N-1:0] eg;
        ev_t          e;
        forever begin
            @(negedge clk);
            if (edge_n >= 1) begin
                et  = 1'b0;
                eto = 1'b0;
                ed  = '0;
                etv = '0;
                while (sb.size() > 0 && sb[0].at <= edge_n) begin
                    e = sb.pop_front();
                    case (e.kind)
                        0: begin et = 1'b1; etv = e.val; end
                        1: ed = e.val;
                        default: eto = 1'b1;
                    endcase
                end
                eg = (edge_n < g_clear) ? g_val : '0;
                chk("trigger", trigger, et);
                chk("done", done, ed);
                chk("timeout_err", timeout_err, eto);
                chk("gnt", gnt, eg);
                chk("busy", busy, eg != '0);
                chk("grant_id", grant_id, e_id);
                if (et) chk("trigger_gnt", gnt, etv);
            end
        end
    end

    // Stimulus: directed scenarios followed by two randomized phases.
    initial begin
        rst        = 1'b0;
        req        = '0;
        force_busy = 1'b0;
        stuck_mask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        req = 4'b0010; repeat (3) @(negedge clk);
        req = 4'b0000; repeat (8) @(negedge clk);

        req = 4'b1111; repeat (30) @(negedge clk);
        req = 4'b0000; repeat (8) @(negedge clk);

        req = 4'b0100; @(negedge clk);
        req = 4'b0011; repeat (14) @(negedge clk);
        req = 4'b0000; repeat (8) @(negedge clk);

        stuck_mask = 4'b0001;
        req = 4'b0001; repeat (2) @(negedge clk);
        req = 4'b0010; repeat (30) @(negedge clk);
        req = 4'b0000; repeat (8) @(negedge clk);
        stuck_mask = 4'b0000;

        force_busy = 1'b1;
        req = 4'b0001; repeat (8) @(negedge clk);
        force_busy = 1'b0; repeat (3) @(negedge clk);
        req = 4'b0000; repeat (8) @(negedge clk);

        req = 4'b0100; repeat (3) @(negedge clk);
        rst = 1'b0; @(negedge clk);
        rst = 1'b1;
        req = 4'b1001; repeat (4) @(negedge clk);
        req = 4'b0000; repeat (8) @(negedge clk);

        for (int ph = 0; ph < 2; ph++) begin
            stuck_mask = (ph == 0) ? 4'b0000 : 4'b0100;
            for (int k = 0; k < 300; k++) begin
                if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
                @(negedge clk);
            end
            req = 4'b0000;
            repeat (25) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
